// File: rtl/piano_pkg.sv
// Shared display constants for the piano frame: VGA timing, keyboard geometry, colours,
// and the map from white-key index to chromatic key number.
package piano_pkg;

  localparam int H_DISP       = 1280;
  localparam int H_TOTAL      = 1688;
  localparam int V_DISP       = 1024;
  localparam int V_TOTAL      = 1066;
  localparam int KB_LEFT      = 80;
  localparam int KB_TOP       = 704;
  localparam int WHITE_W      = 80;
  localparam int BLACK_HALF   = 24;
  localparam int BLACK_H      = 192;
  localparam int FLASH_FRAMES = 8;
  localparam int PIPE_LEAD    = 2;

  localparam int HW = 11;
  localparam int VW = 11;
  localparam int CW = 7;

  localparam logic [11:0] COL_OFF      = 12'h000;
  localparam logic [11:0] COL_BG       = 12'h124;
  localparam logic [11:0] COL_BLACK    = 12'h000;
  localparam logic [11:0] COL_BLACK_PR = 12'h44F;
  localparam logic [11:0] COL_FLASH    = 12'hFF0;
  localparam logic [11:0] COL_BORDER   = 12'h222;
  localparam logic [11:0] COL_WHITE    = 12'hFFF;
  localparam logic [11:0] COL_WHITE_PR = 12'h8CF;

  localparam logic [3:0] WHITE_SEMI [8] = '{4'd0, 4'd2, 4'd4, 4'd5, 4'd7, 4'd9, 4'd11, 4'd0};

  typedef struct packed {
    logic       act;
    logic       kb;
    logic       border;
    logic       black;
    logic [4:0] key;
  } pix_s1_t;

  function automatic logic [2:0] white_pos(input logic [3:0] w);
    return (w >= 4'd7) ? 3'(w - 4'd7) : w[2:0];
  endfunction

  function automatic logic [4:0] white_key(input logic [3:0] w);
    return ((w >= 4'd7) ? 5'd12 : 5'd0) + {1'b0, WHITE_SEMI[white_pos(w)]};
  endfunction

  // E and B have no sharp above them
  function automatic logic black_after(input logic [3:0] w);
    logic [2:0] n;
    n = white_pos(w);
    return (n != 3'd2) && (n != 3'd6);
  endfunction

endpackage

// File: rtl/key_flash_ctr.sv
// Per-key flash timer: reloads on a newly latched press, counts down once per frame while held.
// Updates only on the frame latch strobe; no backpressure.
module key_flash_ctr #(
  parameter int FLASH_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       latch,
  input  logic       key_old,
  input  logic       key_new,
  output logic [3:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (latch) begin
      if (!key_new) begin
        cnt <= 4'd0;
      end else if (!key_old) begin
        cnt <= 4'(FLASH_FRAMES);
      end else if (cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

endmodule

// File: rtl/piano_key_render.sv
// Two-octave piano keyboard pixel source, running lead-ahead VGA counters so RGB lines up
// with the VGA stage's own counters; two-stage pipeline, no backpressure.
module piano_key_render #(
  parameter int H_DISP       = piano_pkg::H_DISP,
  parameter int H_TOTAL      = piano_pkg::H_TOTAL,
  parameter int V_DISP       = piano_pkg::V_DISP,
  parameter int V_TOTAL      = piano_pkg::V_TOTAL,
  parameter int KB_LEFT      = piano_pkg::KB_LEFT,
  parameter int KB_TOP       = piano_pkg::KB_TOP,
  parameter int WHITE_W      = piano_pkg::WHITE_W,
  parameter int BLACK_HALF   = piano_pkg::BLACK_HALF,
  parameter int BLACK_H      = piano_pkg::BLACK_H,
  parameter int FLASH_FRAMES = piano_pkg::FLASH_FRAMES,
  parameter int PIPE_LEAD    = piano_pkg::PIPE_LEAD
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [23:0] KEYS,
  output logic [11:0] RGB,
  output logic        FRAME_TICK
);
  import piano_pkg::*;

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT   = HW'(H_DISP);
  localparam logic [HW-1:0] H_VSTEP = HW'(H_DISP - 1);
  localparam logic [HW-1:0] H_START = HW'(PIPE_LEAD);
  localparam logic [HW-1:0] KB_LM1  = HW'(KB_LEFT - 1);
  localparam logic [HW-1:0] KB_L    = HW'(KB_LEFT);
  localparam logic [HW-1:0] KB_R    = HW'(KB_LEFT + 14 * WHITE_W - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT   = VW'(V_DISP);
  localparam logic [VW-1:0] KB_T    = VW'(KB_TOP);
  localparam logic [VW-1:0] BLK_BOT = VW'(KB_TOP + BLACK_H - 1);
  localparam logic [CW-1:0] COL_END = CW'(WHITE_W - 1);
  localparam logic [CW-1:0] BLK_R   = CW'(WHITE_W - BLACK_HALF);
  localparam logic [CW-1:0] BLK_L   = CW'(BLACK_HALF);

  logic [HW-1:0] h_l;
  logic [VW-1:0] v_l;
  logic [CW-1:0] col;
  logic [3:0]    w;
  logic [3:0]    w_prev;
  logic          in_kb_h;
  logic          latch;
  logic [23:0]   keys_s1, keys_s2, key_frame;
  logic [3:0]    flash_cnt [24];
  pix_s1_t       s1_d, s1_q;
  logic          blk_r, blk_l;
  logic [11:0]   rgb_d;
  logic          pressed, flashing;

  assign in_kb_h    = (h_l >= KB_L) && (h_l <= KB_R);
  assign latch      = (h_l == '0) && (v_l == V_ACT);
  assign FRAME_TICK = latch;
  assign w_prev     = w - 4'd1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      h_l <= H_START;
      v_l <= '0;
    end else begin
      h_l <= (h_l == H_LAST) ? '0 : h_l + 1'b1;
      if (h_l == H_VSTEP) begin
        v_l <= (v_l == V_LAST) ? '0 : v_l + 1'b1;
      end
    end
  end

  // Column/white-key tracking replaces a divide of (h_l - KB_LEFT) by WHITE_W
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      col <= '0;
      w   <= '0;
    end else if (h_l == KB_LM1) begin
      col <= '0;
      w   <= '0;
    end else if (in_kb_h) begin
      if (col == COL_END) begin
        col <= '0;
        w   <= (w == 4'd13) ? 4'd0 : w + 4'd1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      keys_s1   <= '0;
      keys_s2   <= '0;
      key_frame <= '0;
    end else begin
      keys_s1 <= KEYS;
      keys_s2 <= keys_s1;
      if (latch) begin
        key_frame <= keys_s2;
      end
    end
  end

  for (genvar k = 0; k < 24; k++) begin : g_flash
    key_flash_ctr #(.FLASH_FRAMES(FLASH_FRAMES)) u_flash (
      .clk     (CLK),
      .rst     (RST),
      .latch   (latch),
      .key_old (key_frame[k]),
      .key_new (keys_s2[k]),
      .cnt     (flash_cnt[k])
    );
  end

  always_comb begin
    blk_r       = (col >= BLK_R) && black_after(w);
    blk_l       = (col < BLK_L) && (w != 4'd0) && black_after(w_prev);
    s1_d        = '0;
    s1_d.act    = (h_l < H_ACT) && (v_l < V_ACT);
    s1_d.kb     = s1_d.act && in_kb_h && (v_l >= KB_T);
    s1_d.black  = (v_l >= KB_T) && (v_l <= BLK_BOT) && (blk_r || blk_l);
    s1_d.border = (col == '0) || (v_l == KB_T);
    if (s1_d.black && blk_r) begin
      s1_d.key = white_key(w) + 5'd1;
    end else if (s1_d.black) begin
      s1_d.key = white_key(w_prev) + 5'd1;
    end else begin
      s1_d.key = white_key(w);
    end
  end

  always_comb begin
    pressed  = key_frame[s1_q.key];
    flashing = (flash_cnt[s1_q.key] != 4'd0);
    rgb_d    = COL_OFF;
    if (!s1_q.act) begin
      rgb_d = COL_OFF;
    end else if (!s1_q.kb) begin
      rgb_d = COL_BG;
    end else if (s1_q.black) begin
      rgb_d = flashing ? COL_FLASH : (pressed ? COL_BLACK_PR : COL_BLACK);
    end else if (s1_q.border) begin
      rgb_d = COL_BORDER;
    end else begin
      rgb_d = flashing ? COL_FLASH : (pressed ? COL_WHITE_PR : COL_WHITE);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_q <= '0;
      RGB  <= '0;
    end else begin
      s1_q <= s1_d;
      RGB  <= rgb_d;
    end
  end

endmodule

// File: tb/tb_piano_key_render.sv
// Bench for piano_key_render on a shrunken frame geometry: a pixel-level model of the
// keyboard picture is compared with RGB/FRAME_TICK every cycle, plus pinned literal pixels.
module tb_piano_key_render;

  localparam int HD = 96, HT = 104, VD = 16, VT = 19;
  localparam int KL = 4, KT = 8, WW = 6, BHALF = 2, BH = 4, FF = 8;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        RST;
  logic [23:0] KEYS;
  logic [11:0] RGB;
  logic        FRAME_TICK;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  piano_key_render #(
    .H_DISP(HD), .H_TOTAL(HT), .V_DISP(VD), .V_TOTAL(VT),
    .KB_LEFT(KL), .KB_TOP(KT), .WHITE_W(WW), .BLACK_HALF(BHALF),
    .BLACK_H(BH), .FLASH_FRAMES(FF), .PIPE_LEAD(2)
  ) dut (
    .CLK(clk), .RST(RST), .KEYS(KEYS), .RGB(RGB), .FRAME_TICK(FRAME_TICK)
  );

  // Model state: VGA-stage position, synchronised keys, latched keys, frames since press
  int          mh, mv, since;
  logic [23:0] ks1, ks2, kf;
  int          age [24];

  function automatic int nh(int h);
    return (h == HT - 1) ? 0 : h + 1;
  endfunction

  function automatic int nv(int h, int v);
    if (h != HD - 1) return v;
    return (v == VT - 1) ? 0 : v + 1;
  endfunction

  // The renderer runs two pixels ahead of the VGA stage, so its latch is two steps away
  function automatic bit latch_now(int h, int v);
    int h1, v1;
    h1 = nh(h);
    v1 = nv(h, v);
    return (nh(h1) == 0) && (nv(h1, v1) == VD);
  endfunction

  function automatic int wsemi(int w);
    int s;
    case (w % 7)
      0: s = 0;
      1: s = 2;
      2: s = 4;
      3: s = 5;
      4: s = 7;
      5: s = 9;
      default: s = 11;
    endcase
    return s + 12 * (w / 7);
  endfunction

  function automatic bit has_sharp(int w);
    return (w % 7 != 2) && (w % 7 != 6);
  endfunction

  function automatic logic [11:0] key_col(int k, bit black);
    if (kf[k] && age[k] < FF) return 12'hFF0;
    if (kf[k]) return black ? 12'h44F : 12'h8CF;
    return black ? 12'h000 : 12'hFFF;
  endfunction

  function automatic logic [11:0] pix(int x, int y);
    int rx, w, c;
    if (x >= HD || y >= VD) return 12'h000;
    if (x < KL || x >= KL + 14 * WW || y < KT) return 12'h124;
    rx = x - KL;
    w  = rx / WW;
    c  = rx % WW;
    if (y < KT + BH) begin
      if (c >= WW - BHALF && has_sharp(w)) return key_col(wsemi(w) + 1, 1'b1);
      if (c < BHALF && w > 0 && has_sharp(w - 1)) return key_col(wsemi(w - 1) + 1, 1'b1);
    end
    if (c == 0 || y == KT) return 12'h222;
    return key_col(wsemi(w), 1'b0);
  endfunction

  always @(posedge clk) begin
    if (RST) begin
      mh    <= 0;
      mv    <= 0;
      since <= 0;
      ks1   <= '0;
      ks2   <= '0;
      kf    <= '0;
      for (int k = 0; k < 24; k++) age[k] <= 15;
    end else begin
      mh    <= nh(mh);
      mv    <= nv(mh, mv);
      since <= (since < 10) ? since + 1 : since;
      ks1   <= KEYS;
      ks2   <= ks1;
      if (latch_now(mh, mv)) begin
        kf <= ks2;
        for (int k = 0; k < 24; k++) begin
          if (ks2[k] && !kf[k]) age[k] <= 0;
          else if (ks2[k]) age[k] <= (age[k] < 15) ? age[k] + 1 : 15;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [11:0] exp_rgb;
    logic        exp_tick;
    if (!RST) begin
      exp_rgb  = (since < 2) ? 12'h000 : pix(mh, mv);
      exp_tick = latch_now(mh, mv);
      total++;
      if (RGB !== exp_rgb) begin
        bad++;
        $display("FAIL rgb at (%0d,%0d) t=%0t: got %h want %h", mh, mv, $time, RGB, exp_rgb);
      end
      total++;
      if (FRAME_TICK !== exp_tick) begin
        bad++;
        $display("FAIL frame_tick at (%0d,%0d): got %b want %b", mh, mv, FRAME_TICK, exp_tick);
      end
    end
  end

  task automatic check_px(input int x, input int y, input logic [11:0] exp, input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(mh == x && mv == y) && n < 2 * FRAME);
    total++;
    if (!(mh == x && mv == y)) begin
      bad++;
      $display("FAIL %s: pixel (%0d,%0d) not reached within %0d cycles", nm, x, y, n);
    end else if (RGB !== exp) begin
      bad++;
      $display("FAIL %s: rgb=%h required %h", nm, RGB, exp);
    end
  endtask

  task automatic wait_tick(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (FRAME_TICK !== 1'b1 && n < 2 * FRAME);
    total++;
    if (FRAME_TICK !== 1'b1) begin
      bad++;
      $display("FAIL %s: no FRAME_TICK within %0d cycles (got %b, required 1)", nm, n, FRAME_TICK);
    end
  endtask

  localparam int Y_LOW = VD - 1;

  initial begin
    RST  = 1'b1;
    KEYS = '0;
    repeat (3) @(negedge clk);
    total++;
    if (RGB !== 12'h000 || FRAME_TICK !== 1'b0) begin
      bad++;
      $display("FAIL reset_out: rgb=%h tick=%b required 000/0", RGB, FRAME_TICK);
    end
    RST = 1'b0;

    // Idle keyboard after one frame
    wait_tick("first_tick");
    check_px(1, 2, 12'h124, "background");
    check_px(KL, KT - 2 + BH + 2, 12'h222, "white_border");
    check_px(KL + WW / 2, KT, 12'h222, "top_border");
    check_px(KL + WW, KT + 1, 12'h000, "csharp_idle");
    check_px(HD + 2, 1, 12'h000, "outside_active");
    check_px(KL + WW / 2, Y_LOW, 12'hFFF, "c4_idle");

    // C4 pressed mid-frame: unchanged until the latch, then 8 flash frames
    check_px(0, 3, 12'h124, "bg_c4");
    KEYS[0] = 1'b1;
    check_px(KL + WW / 2, Y_LOW, 12'hFFF, "c4_before_latch");
    for (int f = 0; f < FF; f++) begin
      wait_tick("c4_tick");
      check_px(KL + WW / 2, Y_LOW, 12'hFF0, "c4_flash");
    end
    wait_tick("c4_tick_end");
    check_px(KL + WW / 2, Y_LOW, 12'h8CF, "c4_pressed");

    // C#4 flashes then shows pressed; neighbouring whites stay white
    KEYS[0] = 1'b0;
    KEYS[1] = 1'b1;
    wait_tick("cs_tick");
    check_px(KL + WW / 2, Y_LOW, 12'hFFF, "c4_released");
    check_px(KL + WW, KT + 1, 12'hFF0, "csharp_flash");
    check_px(KL + WW + 3, Y_LOW, 12'hFFF, "d4_unchanged");
    repeat (FF) wait_tick("cs_tick_n");
    check_px(KL + WW, KT + 1, 12'h44F, "csharp_pressed");
    KEYS[1] = 1'b0;

    // Short B5 pulse between latches never shows
    wait_tick("b5_tick");
    check_px(0, 3, 12'h124, "bg_b5");
    KEYS[23] = 1'b1;
    repeat (100) @(negedge clk);
    KEYS[23] = 1'b0;
    wait_tick("b5_tick2");
    check_px(KL + 13 * WW + 3, Y_LOW, 12'hFFF, "b5_unseen");

    // E4 press / release / re-press reloads the flash
    KEYS[4] = 1'b1;
    wait_tick("e4_f0");
    check_px(KL + 2 * WW + 3, Y_LOW, 12'hFF0, "e4_first_flash");
    KEYS[4] = 1'b0;
    wait_tick("e4_f1");
    check_px(KL + 2 * WW + 3, Y_LOW, 12'hFFF, "e4_released");
    KEYS[4] = 1'b1;
    wait_tick("e4_f2");
    check_px(KL + 2 * WW + 3, Y_LOW, 12'hFF0, "e4_reflash");
    wait_tick("e4_f3");
    check_px(KL + 2 * WW + 3, Y_LOW, 12'hFF0, "e4_reflash2");

    // Random key patterns at random points in the frame
    for (int i = 0; i < 4; i++) begin
      wait_tick("rand_tick");
      repeat ($urandom_range(20, FRAME - 100)) @(negedge clk);
      KEYS = 24'($urandom);
    end

    // Mid-frame reset clears the latched keys even with C4 held
    KEYS[0] = 1'b1;
    wait_tick("pre_rst_tick");
    check_px(30, 5, 12'h124, "bg_pre_rst");
    RST = 1'b1;
    repeat (3) @(negedge clk);
    RST = 1'b0;
    check_px(KL + WW / 2, Y_LOW, 12'hFFF, "rst_clears_keys");
    wait_tick("post_rst_tick");
    check_px(KL + WW / 2, Y_LOW, 12'hFF0, "post_rst_flash");
    wait_tick("final_tick");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
